// File: rtl/store_buffer_param.sv
// store_buffer_param: N-entry circular store buffer between the store path and
// the dcache write port. Stores enter in program order, drain oldest first,
// and loads receive byte-granular forwarding (youngest store wins per byte).
// Optional build macro STORE_BUFFER_COALESCE_EN: stores to the same word as the
// youngest entry (when that entry is not the in-flight head) merge into it.
module store_buffer_param #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int SEL_W = DATA_W / 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid_i,
  output logic              st_ready_o,
  input  logic [ADDR_W-1:0] st_addr_i,
  input  logic [DATA_W-1:0] st_data_i,
  input  logic [SEL_W-1:0]  st_sel_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  output logic [SEL_W-1:0]  ld_fwd_sel_o,
  output logic [DATA_W-1:0] ld_fwd_data_o,
  output logic              dc_req_o,
  output logic [ADDR_W-1:0] dc_addr_o,
  output logic [DATA_W-1:0] dc_data_o,
  output logic [SEL_W-1:0]  dc_sel_o,
  input  logic              dc_ack_i,
  input  logic              drain_i,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic              valid_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem  [DEPTH];
  logic [SEL_W-1:0]  sel_mem   [DEPTH];

  logic full;
  logic push;
  logic pop;
  logic alloc;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty_o  = (count == '0);
  assign count_o  = count;
  assign dc_req_o = !empty_o;
  assign pop      = dc_req_o && dc_ack_i;
  assign push     = st_valid_i && st_ready_o;

`ifdef STORE_BUFFER_COALESCE_EN
  logic [PTR_W-1:0] youngest;
  logic             merge;
  logic             do_merge;

  // With two or more entries the youngest is never the in-flight head, so a
  // matching store can be folded into it, even when the buffer is full.
  assign youngest   = tail - 1'b1;
  assign merge      = (count >= CNT_W'(2)) && valid_mem[youngest] &&
                      (addr_mem[youngest] == st_addr_i);
  assign st_ready_o = (!full || merge) && !drain_i;
  assign do_merge   = push && merge;
  assign alloc      = push && (|st_sel_i) && !merge;
`else
  assign st_ready_o = !full && !drain_i;
  assign alloc      = push && (|st_sel_i);
`endif

  // Head entry goes straight to the dcache port; zero when nothing is pending.
  assign dc_addr_o = dc_req_o ? addr_mem[head] : '0;
  assign dc_data_o = dc_req_o ? data_mem[head] : '0;
  assign dc_sel_o  = dc_req_o ? sel_mem[head]  : '0;

  // FIFO state: allocate at tail, retire at head on dcache acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        valid_mem[i] <= 1'b0;
        addr_mem[i]  <= '0;
        data_mem[i]  <= '0;
        sel_mem[i]   <= '0;
      end
    end else begin
      if (alloc) begin
        valid_mem[tail] <= 1'b1;
        addr_mem[tail]  <= st_addr_i;
        data_mem[tail]  <= st_data_i;
        sel_mem[tail]   <= st_sel_i;
        tail            <= tail + 1'b1;
      end
`ifdef STORE_BUFFER_COALESCE_EN
      if (do_merge) begin
        sel_mem[youngest] <= sel_mem[youngest] | st_sel_i;
        for (int b = 0; b < SEL_W; b++) begin
          if (st_sel_i[b]) begin
            data_mem[youngest][8*b +: 8] <= st_data_i[8*b +: 8];
          end
        end
      end
`endif
      if (pop) begin
        valid_mem[head] <= 1'b0;
        head            <= head + 1'b1;
      end
      count <= count + CNT_W'(alloc) - CNT_W'(pop);
    end
  end

  // Entry indices ordered oldest (offset 0) to youngest.
  logic [PTR_W-1:0] order [DEPTH];
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_order
      assign order[gi] = head + PTR_W'(gi);
    end

    for (gi = 0; gi < SEL_W; gi++) begin : g_fwd
      logic       hit;
      logic [7:0] byte_val;
      // Scan oldest to youngest so the youngest matching store wins this byte.
      always_comb begin
        hit      = 1'b0;
        byte_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
          if (valid_mem[order[i]] && (addr_mem[order[i]] == ld_addr_i) &&
              sel_mem[order[i]][gi]) begin
            hit      = 1'b1;
            byte_val = data_mem[order[i]][8*gi +: 8];
          end
        end
      end
      assign ld_fwd_sel_o[gi]         = hit;
      assign ld_fwd_data_o[8*gi +: 8] = byte_val;
    end
  endgenerate

endmodule

// File: tb/tb_store_buffer_param.sv
// Testbench for store_buffer_param: queue-based reference model, decoupled
// scoreboard monitor on the dcache port, directed scenarios plus random traffic.
module tb_store_buffer_param;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic        clk;
  logic        rst;
  logic        st_valid_i;
  logic        st_ready_o;
  logic [31:0] st_addr_i;
  logic [31:0] st_data_i;
  logic [3:0]  st_sel_i;
  logic [31:0] ld_addr_i;
  logic [3:0]  ld_fwd_sel_o;
  logic [31:0] ld_fwd_data_o;
  logic        dc_req_o;
  logic [31:0] dc_addr_o;
  logic [31:0] dc_data_o;
  logic [3:0]  dc_sel_o;
  logic        dc_ack_i;
  logic        drain_i;
  logic        empty_o;
  logic [CNT_W-1:0] count_o;

  store_buffer_param #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .st_valid_i(st_valid_i), .st_ready_o(st_ready_o),
    .st_addr_i(st_addr_i), .st_data_i(st_data_i), .st_sel_i(st_sel_i),
    .ld_addr_i(ld_addr_i), .ld_fwd_sel_o(ld_fwd_sel_o), .ld_fwd_data_o(ld_fwd_data_o),
    .dc_req_o(dc_req_o), .dc_addr_o(dc_addr_o), .dc_data_o(dc_data_o), .dc_sel_o(dc_sel_o),
    .dc_ack_i(dc_ack_i), .drain_i(drain_i), .empty_o(empty_o), .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
  } ent_t;

  ent_t q[$];            // pending stores, oldest first = expected drain order
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_ready(input logic [31:0] a, input logic drn);
    logic r;
    r = (q.size() < DEPTH);
`ifdef STORE_BUFFER_COALESCE_EN
    if (q.size() >= 2 && q[q.size()-1].addr == a) r = 1'b1;
`endif
    return r && !drn;
  endfunction

  task automatic model_push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    ent_t e;
    if (s == 4'h0) return;
`ifdef STORE_BUFFER_COALESCE_EN
    if (q.size() >= 2 && q[q.size()-1].addr == a) begin
      e = q[q.size()-1];
      for (int b = 0; b < 4; b++) if (s[b]) e.data[8*b +: 8] = d[8*b +: 8];
      e.sel = e.sel | s;
      q[q.size()-1] = e;
      return;
    end
`endif
    e.addr = a; e.data = d; e.sel = s;
    q.push_back(e);
  endtask

  // One clock: drive at negedge, check combinational/registered outputs, then
  // account for the store that the next rising edge accepts.
  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic ack, input logic drn,
                       input logic [31:0] la);
    logic [3:0]  fs;
    logic [31:0] fd;
    logic        rdy;
    @(negedge clk);
    st_valid_i = v; st_addr_i = a; st_data_i = d; st_sel_i = s;
    dc_ack_i = ack; drain_i = drn; ld_addr_i = la;
    #1;
    fs = '0; fd = '0;
    foreach (q[i]) begin
      if (q[i].addr == la) begin
        for (int b = 0; b < 4; b++) begin
          if (q[i].sel[b]) begin
            fs[b] = 1'b1;
            fd[8*b +: 8] = q[i].data[8*b +: 8];
          end
        end
      end
    end
    rdy = model_ready(a, drn);
    chk("count", 64'(count_o), 64'(q.size()));
    chk("empty", 64'(empty_o), 64'(q.size() == 0));
    chk("dc_req", 64'(dc_req_o), 64'(q.size() != 0));
    chk("st_ready", 64'(st_ready_o), 64'(rdy));
    chk("fwd_sel", 64'(ld_fwd_sel_o), 64'(fs));
    chk("fwd_data", 64'(ld_fwd_data_o), 64'(fd));
    $display("cyc t=%0t v=%0d a=%0h d=%0h s=%0h ack=%0d drn=%0d cnt=%0d rdy=%0d",
             $time, v, a, d, s, ack, drn, count_o, st_ready_o);
    if (v && rdy) model_push(a, d, s);
  endtask

  task automatic drain_all();
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
    end
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    chk("drain_empty", 64'(empty_o), 64'(1));
  endtask

  // Scoreboard monitor: compare the presented head write against the oldest
  // pending store and retire it when the dcache acknowledges.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && dc_req_o) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL dc_unexpected actual=req addr=0x%0h required=no request", dc_addr_o);
        end else begin
          chk("dc_addr", 64'(dc_addr_o), 64'(q[0].addr));
          chk("dc_data", 64'(dc_data_o), 64'(q[0].data));
          chk("dc_sel", 64'(dc_sel_o), 64'(q[0].sel));
          if (dc_ack_i) begin
            $display("drain addr=%0h data=%0h sel=%0h", dc_addr_o, dc_data_o, dc_sel_o);
            void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; st_valid_i = 0; st_addr_i = 0; st_data_i = 0; st_sel_i = 0;
    ld_addr_i = 0; dc_ack_i = 0; drain_i = 0;
    @(negedge clk); #1;
    chk("rst_ready", 64'(st_ready_o), 64'(1));
    chk("rst_empty", 64'(empty_o), 64'(1));
    chk("rst_count", 64'(count_o), 64'(0));
    chk("rst_dc_req", 64'(dc_req_o), 64'(0));
    chk("rst_dc_addr", 64'(dc_addr_o), 64'(0));
    chk("rst_fwd_sel", 64'(ld_fwd_sel_o), 64'(0));
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 2; i++) cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);

    // Fill to DEPTH without ack, then ack once.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h10 + 32'(i), $urandom, 4'hF, 1'b0, 1'b0, 32'h10);
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h11);
    chk("full_dc_addr", 64'(dc_addr_o), 64'h10);
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h12);
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h13);
    chk("after_ack_dc_addr", 64'(dc_addr_o), 64'h11);

    // Refill, then push while full together with an ack: push rejected.
    cycle(1'b1, 32'h14, $urandom, 4'hF, 1'b0, 1'b0, 32'h14);
    cycle(1'b1, 32'h15, $urandom, 4'hF, 1'b1, 1'b0, 32'h15);
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h15);
    chk("full_push_ack_count", 64'(count_o), 64'(3));
    // Steady push+ack at count 2; pointers wrap.
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 32'h60 + 32'(i), $urandom, 4'hF, 1'b1, 1'b0, 32'h60 + 32'(i));
    drain_all();

    // Byte forwarding, youngest wins.
    cycle(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, 1'b0, 32'h20);
    cycle(1'b1, 32'h20, 32'hAABB0000, 4'hC, 1'b0, 1'b0, 32'h20);
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h20);
    chk("fwd_20_data", 64'(ld_fwd_data_o), 64'hAABB3344);
    chk("fwd_20_sel", 64'(ld_fwd_sel_o), 64'hF);
    drain_all();

    // drain_i with 3 entries, ack every other cycle.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h50 + 32'(i), $urandom, 4'hF, 1'b0, 1'b0, 32'h50);
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      cycle(1'b1, 32'h58, $urandom, 4'hF, 1'(i % 2), 1'b1, 32'h51);
    end
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0);
    chk("drain_i_empty", 64'(empty_o), 64'(1));
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);

    // Coalescing scenario (head in flight never merges).
    cycle(1'b1, 32'h30, 32'h000000FF, 4'h1, 1'b0, 1'b0, 32'h30);
    cycle(1'b1, 32'h30, 32'h0000EE00, 4'h2, 1'b0, 1'b0, 32'h30);
    cycle(1'b1, 32'h30, 32'h00DD0000, 4'h4, 1'b0, 1'b0, 32'h30);
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h30);
`ifdef STORE_BUFFER_COALESCE_EN
    chk("coal_count", 64'(count_o), 64'(2));
`else
    chk("coal_count", 64'(count_o), 64'(3));
`endif
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h30);
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h30);
`ifdef STORE_BUFFER_COALESCE_EN
    chk("coal_sel", 64'(dc_sel_o), 64'h6);
    chk("coal_data", 64'(dc_data_o), 64'h00DDEE00);
`else
    chk("coal_sel", 64'(dc_sel_o), 64'h2);
    chk("coal_data", 64'(dc_data_o), 64'h0000EE00);
`endif
    drain_all();

    // Random traffic on a small address set to provoke overlaps.
    for (int i = 0; i < 300; i++) begin
      logic [3:0] s;
      s = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      cycle(1'($urandom_range(0, 1)), 32'h40 + 32'($urandom_range(0, 3)), $urandom, s,
            1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
            32'h40 + 32'($urandom_range(0, 3)));
    end
    drain_all();

    // Asynchronous reset with three stores pending and the head in flight.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h70 + 32'(i), $urandom, 4'hF, 1'b0, 1'b0, 32'h70);
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h70);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_count", 64'(count_o), 64'(0));
    chk("async_rst_dc_req", 64'(dc_req_o), 64'(0));
    chk("async_rst_fwd", 64'(ld_fwd_sel_o), 64'(0));
    q.delete();
    @(negedge clk); rst = 1'b0;
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h70);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/store_buffer_param.md
Name: store_buffer_param

Overview:
- Parametrised N-entry store buffer between the LSU/MMU store path and the dcache write port. Generalises the single-entry store buffer in mem_top.
- Stores are accepted in program order and drained to the dcache one at a time, oldest first.
- Loads get byte-granular forwarding from pending stores, with the youngest store winning each byte.
- A drain request empties the buffer before a dcache flush or fence.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2
- ADDR_W, 32, word address width (byte offset excluded)
- DATA_W, 32, data width; multiple of 8
- SEL_W, DATA_W/8, byte-enable width; derived, not overridable

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- st_valid_i  in  1  store request valid
- st_ready_o  out  1  buffer can accept store
- st_addr_i  in  ADDR_W  store word address
- st_data_i  in  DATA_W  store data
- st_sel_i  in  SEL_W  store byte enables
- ld_addr_i  in  ADDR_W  load lookup word address (combinational lookup)
- ld_fwd_sel_o  out  SEL_W  bytes covered by pending stores at ld_addr_i
- ld_fwd_data_o  out  DATA_W  forwarded bytes; uncovered bytes are 0
- dc_req_o  out  1  drain request to dcache
- dc_addr_o  out  ADDR_W  head entry address
- dc_data_o  out  DATA_W  head entry data
- dc_sel_o  out  SEL_W  head entry byte enables
- dc_ack_i  in  1  dcache accepted the head write
- drain_i  in  1  request full drain (level)
- empty_o  out  1  no valid entries
- count_o  out  $clog2(DEPTH)+1  valid entry count

Behaviour:
- Reset (async, rst=1):
  - All entries invalid; head/tail pointers and count are 0.
  - Outputs: st_ready_o=1, dc_req_o=0, empty_o=1, count_o=0, ld_fwd_sel_o=0, ld_fwd_data_o=0; dc_addr/data/sel=0.
  - Reset mid-drain drops the in-flight write; the bench must not ack after reset.
- Storage: circular FIFO, entry = {valid, addr, data, sel}.
  - Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0.
  - count tracks full vs empty.
- Push:
  - Occurs when st_valid_i && st_ready_o at the rising edge; the entry is written at tail and tail increments.
  - A store with st_sel_i=0 is accepted and discarded (no entry, count unchanged).
- st_ready_o = (count != DEPTH) && !drain_i.
  - No same-cycle push-on-pop bypass when full: with count=DEPTH, ready stays 0 in the cycle dc_ack_i pops.
- Drain (combinational):
  - dc_req_o = !empty; dc_addr/data/sel = head entry.
  - Outputs stay stable while dc_req_o=1 and dc_ack_i=0.
  - On dc_ack_i && dc_req_o, head invalidates and increments; the next entry is presented in the following cycle.
  - dc_ack_i while dc_req_o=0 is ignored.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Latency: a store accepted at edge k is seen on dc_req_o after edge k (empty buffer), and in forwarding after edge k.
- Forwarding:
  - For each byte b, the youngest valid entry with addr==ld_addr_i and sel[b]=1 supplies data byte b and sets ld_fwd_sel_o[b].
  - The entry being acked this cycle still forwards (the dcache write lands at the same edge).
  - The load unit stalls on partial coverage; this block takes no action.
- drain_i: blocks new stores; draining continues normally; empty_o=1 signals completion. The caller deasserts drain_i.
- empty_o = (count==0); count_o is registered.

Optional Feature:
- Macro STORE_BUFFER_COALESCE_EN.
- Defined:
  - A store whose address matches the youngest valid entry (tail-1) merges into that entry: bytes with st_sel_i=1 are overwritten and sel becomes the OR of old and new.
  - No new entry is allocated, even when the buffer is full; st_ready_o still applies, except when full and the store would merge.
  - No merge if that entry is the head and dc_req_o=1 (in-flight to dcache); a normal allocation occurs instead.
- Undefined: every accepted store allocates an entry.

Test Plan:
- Reset then idle -> empty_o=1, count_o=0, dc_req_o=0, st_ready_o=1; assert rst mid-drain with count=3 -> count_o=0 and dc_req_o=0 asynchronously.
- Push DEPTH=4 stores to addr 0x10..0x13, no ack -> count_o=4, st_ready_o=0, dc_addr_o=0x10; ack one cycle -> dc_addr_o=0x11 next cycle, count_o=3.
- Stores to addr 0x20: data 0x11223344 sel 0xF, then 0xAABB0000 sel 0xC; ld_addr_i=0x20 -> ld_fwd_sel_o=0xF, ld_fwd_data_o=0xAABB3344.
- Full buffer with push and ack in the same cycle -> push rejected (ready=0), count_o=3; then push and ack with count=2 -> count stays 2, pointers wrap correctly across 8 pushes.
- drain_i=1 with 3 entries, ack every other cycle -> st_ready_o=0 throughout, empty_o=1 after 3rd ack.
- COALESCE_EN defined: store 0x30 data 0x000000FF sel 0x1, then 0x30 data 0x0000EE00 sel 0x2 with dc_ack_i held 0 -> count_o=2 (head in flight); third store to 0x30 data 0x00DD0000 sel 0x4 -> count_o=2, second entry sel=0x6, data=0x00DDEE00. Undefined: count_o=3.
